// File: rtl/quad_encoder_emu.sv
// Multi-channel quadrature encoder emulator: digital or analog speed requests become a Gray-code
// stream per channel, arbitrated against a synchronized physical encoder on the user port.
module quad_encoder_emu #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int ACCEL_STEPS = 8,
  parameter int DEADZONE    = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic [CHANNELS-1:0]   analog_en,
  input  logic [CHANNELS-1:0]   left,
  input  logic [CHANNELS-1:0]   right,
  input  logic [8*CHANNELS-1:0] analog,
  input  logic [2*CHANNELS-1:0] ext_quad,
  output logic [2*CHANNELS-1:0] quad,
  output logic [CHANNELS-1:0]   src_ext
);

  localparam int ACC_W = $clog2(ACCEL_STEPS + 1);

  logic [DIV_W-1:0] base;
  logic [1:0]       prime_q, prime_d;
  logic             prime_done;

  assign base       = (clkdiv == '0) ? DIV_W'(1) : clkdiv;
  assign prime_done = (prime_q == 2'd3);
  assign prime_d    = prime_done ? prime_q : prime_q + 2'd1;

  // Shared priming counter keeps reset-time pin levels from looking like encoder motion.
  always_ff @(posedge clk_sys) begin
    if (reset) prime_q <= '0;
    else       prime_q <= prime_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [7:0]       raw;
      logic [6:0]       mag;
      logic             act, neg, accel, mode_chg, rev, step, ext_chg;
      logic [1:0]       shamt;
      logic [DIV_W-1:0] shifted, period;
      logic [DIV_W-1:0] timer_q, timer_d;
      logic [ACC_W-1:0] acc_q, acc_d;
      logic [1:0]       phase_q, phase_d, idx, idx_n;
      logic             mode_q, dir_act_q, dir_neg_q;
      logic             src_q, src_d;
      logic [1:0]       sync1_q, sync2_q, hist_q;
      logic [1:0]       quad_q, quad_d;

      assign raw = analog[8*gi +: 8];

      // -128 has no positive counterpart; it saturates to full speed.
      always_comb begin
        if (raw == 8'h80)  mag = 7'd127;
        else if (raw[7])   mag = 7'd0 - raw[6:0];
        else               mag = raw[6:0];
      end

      assign accel = (acc_q >= ACC_W'(ACCEL_STEPS));

      always_comb begin
        if (analog_en[gi]) begin
          act   = (mag >= 7'(DEADZONE));
          neg   = raw[7];
          shamt = mag[6:5];
        end else begin
          act   = left[gi] ^ right[gi];
          neg   = left[gi];
          shamt = {1'b0, accel};
        end
      end

      assign shifted  = base >> shamt;
      assign period   = (shifted == '0) ? DIV_W'(1) : shifted;
      assign mode_chg = (analog_en[gi] != mode_q);
      assign rev      = act && dir_act_q && (neg != dir_neg_q);
      assign ext_chg  = prime_done && (sync2_q != hist_q);

      // Phase index walks 0..3 in the order 00,01,11,10; Gray <-> binary is a single XOR.
      assign idx   = {phase_q[1], ^phase_q};
      assign idx_n = neg ? idx - 2'd1 : idx + 2'd1;

      always_comb begin
        timer_d = timer_q;
        acc_d   = acc_q;
        step    = 1'b0;
        if (!act || rev || mode_chg) begin
          timer_d = '0;
        end else if (timer_q >= period - DIV_W'(1)) begin
          step    = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + DIV_W'(1);
        end

        if (analog_en[gi] || !act || rev || mode_chg) acc_d = '0;
        else if (step && !accel)                      acc_d = acc_q + ACC_W'(1);

        phase_d = step ? {idx_n[1], ^idx_n} : phase_q;
        src_d   = step ? 1'b0 : (ext_chg ? 1'b1 : src_q);
        quad_d  = src_d ? sync2_q : phase_q;
      end

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          timer_q   <= '0;
          acc_q     <= '0;
          phase_q   <= '0;
          mode_q    <= 1'b0;
          dir_act_q <= 1'b0;
          dir_neg_q <= 1'b0;
          src_q     <= 1'b0;
          sync1_q   <= '0;
          sync2_q   <= '0;
          hist_q    <= '0;
          quad_q    <= '0;
        end else begin
          timer_q   <= timer_d;
          acc_q     <= acc_d;
          phase_q   <= phase_d;
          mode_q    <= analog_en[gi];
          dir_act_q <= act;
          dir_neg_q <= neg;
          src_q     <= src_d;
          sync1_q   <= ext_quad[2*gi +: 2];
          sync2_q   <= sync1_q;
          hist_q    <= sync2_q;
          quad_q    <= quad_d;
        end
      end

      assign quad[2*gi +: 2] = quad_q;
      assign src_ext[gi]     = src_q;
    end
  endgenerate

endmodule

// File: doc/quad_encoder_emu.md
Name: quad_encoder_emu

Overview:
Multi-channel successor to the single-channel joystick-to-quadrature converter. It turns digital left/right inputs or a signed analog stick/paddle value into a 2-bit Gray-code quadrature stream per channel, as paddle/spinner game cores expect. Per channel, it arbitrates between the emulated stream and a physical encoder on the user port.
- Sits between hps_io/USER_IN and the game core's Enc_A/Enc_B inputs.
- Replaces the per-core joy2quad instance and its ad-hoc use_io logic.

Parameters:
CHANNELS, 2, number of independent encoder channels
DIV_W, 16, width of the step-period divider
ACCEL_STEPS, 8, consecutive same-direction digital steps before the period halves
DEADZONE, 8, analog magnitude below which no steps are produced

Ports:
clk_sys  in  1  system clock; all logic is on its rising edge
reset  in  1  synchronous, active-high reset
clkdiv  in  DIV_W  base step period in clk_sys cycles, shared by all channels
analog_en  in  CHANNELS  per channel: 0 = digital left/right, 1 = analog speed
left  in  CHANNELS  digital left request, active high
right  in  CHANNELS  digital right request, active high
analog  in  8*CHANNELS  signed two's-complement speed per channel; channel n uses [8n+7:8n]
ext_quad  in  2*CHANNELS  asynchronous physical encoder {A,B} per channel
quad  out  2*CHANNELS  selected quadrature output {A,B} per channel, registered
src_ext  out  CHANNELS  1 = channel currently driven by the physical encoder

Behaviour:
- Reset:
  - quad = 0, src_ext = 0.
  - Emulated phase = 2'b00.
  - Timers and acceleration counters = 0.
  - Synchronizers = 0; prime counter = 0.
- Phase sequence {A,B}:
  - Right/positive steps: 00 -> 01 -> 11 -> 10 -> 00.
  - Left/negative steps: the reverse order.
  - Exactly one phase change per step; wrap-around is continuous.
- Effective period P:
  - base = max(clkdiv, 1); clkdiv = 0 behaves as 1.
  - Digital mode: P = base, or base>>1 once accelerated.
  - Analog mode: P = base >> mag[6:5], where mag = |analog| and -128 is treated as 127.
  - P is clamped to a minimum of 1.
- Per-channel timer:
  - Increments each cycle while a direction is active.
  - When timer >= P-1, a step is emitted and the timer returns to 0.
  - First step occurs P cycles after the direction becomes active.
  - Direction inactive or direction reversal: timer cleared to 0, no step that cycle.
- Digital direction:
  - Exactly one of left/right is active.
  - Both or neither active = idle: no step, timer held at 0, accel counter cleared.
- Analog direction:
  - Sign of analog selects the direction.
  - mag < DEADZONE = idle.
- Acceleration (digital only):
  - Saturating counter of consecutive steps in the same direction.
  - On reaching ACCEL_STEPS, P halves.
  - Cleared on idle, reversal, or switching analog_en.
- Mode switch: analog_en changing clears that channel's timer; the phase is kept.
- External encoder:
  - Two-flop synchronizer per bit, then one history register.
  - Change detect = sync != history.
  - Detection is suppressed for the first 3 cycles after reset, while the pipeline primes, so idle-high pins do not falsely select external.
- Arbitration per channel:
  - External change sets src_ext = 1.
  - Emulated step sets src_ext = 0.
  - Both in the same cycle: the emulated step wins (src_ext = 0).
- Output:
  - quad registered each cycle: src_ext ? synced ext : emulated phase, using the src_ext value from that same update.
  - Latency: emulated step to quad is 1 cycle; ext pin change to quad is 3 cycles.
- Reset mid-operation clears everything as above on the next edge, regardless of inputs.
- Channels are fully independent; the only shared input is clkdiv.

Test Plan:
1. Reset, then clkdiv=4, channel 0 right=1 held for 16 cycles -> quad[1:0] follows 01,11,10,00 at 4-cycle spacing; first change at cycle 5 after right rises; channel 1 stays 00.
2. clkdiv=10, ACCEL_STEPS=8, left held -> first 8 steps 10 cycles apart, subsequent steps 5 apart; release left for 1 cycle and re-press -> spacing returns to 10.
3. left=right=1 with clkdiv=3 -> no phase change over 50 cycles; clkdiv=0 with right -> phase advances every cycle.
4. analog_en=1, clkdiv=64: analog=+5 -> no steps (deadzone); +40 -> period 32, forward; -128 -> period 8, reverse sequence.
5. ext_quad held at 11 through reset -> src_ext stays 0; ext toggles 11->10 -> src_ext=1 and quad=10 three cycles later; then right pressed -> src_ext=0 at the first emulated step.
6. Same-cycle synced ext change and emulated step -> src_ext=0 and quad shows the emulated phase; assert reset mid-stream -> quad=00 and src_ext=0 on the next edge.
